// File: rtl/vscale_htif_pcr_responder_pkg.sv
// Shared constants for the HTIF PCR responder: CSR address map, control widths and FSM encodings.
// Optional cycle CSR is controlled by VSCALE_HTIF_CYCLE_CSR_EN in the consuming modules.
package vscale_htif_pcr_responder_pkg;

    localparam int HTIF_PCR_WIDTH = 64;
    localparam int CSR_ADDR_WIDTH = 12;

    localparam logic [11:0] CSR_ADDR_TO_HOST   = 12'h780;
    localparam logic [11:0] CSR_ADDR_FROM_HOST = 12'h781;
    localparam logic [11:0] CSR_ADDR_CYCLE     = 12'hC00;

    typedef enum logic {
        HTIF_ST_IDLE = 1'b0,
        HTIF_ST_RESP = 1'b1
    } htif_state_t;

endpackage

// File: rtl/vscale_htif_pcr_responder_cycle_counter.sv
// Free-running 64-bit cycle counter backing the optional cycle CSR; zero latency, no backpressure.
// Only built when VSCALE_HTIF_CYCLE_CSR_EN is defined.
`ifdef VSCALE_HTIF_CYCLE_CSR_EN
module vscale_cycle_counter (
    input  logic        clk,
    input  logic        reset,
    output logic [63:0] count
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else begin
            count <= count + 64'd1;
        end
    end

endmodule
`endif

// File: rtl/vscale_htif_pcr_responder.sv
// HTIF PCR target responder serving tohost/fromhost; response one cycle after acceptance, one request
// outstanding (req_ready low until the response handshakes). Cycle CSR under VSCALE_HTIF_CYCLE_CSR_EN.
module vscale_htif_pcr_responder
    import vscale_htif_pcr_responder_pkg::*;
#(
    parameter int PCR_W  = HTIF_PCR_WIDTH,
    parameter int ADDR_W = CSR_ADDR_WIDTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              htif_pcr_req_valid,
    output logic              htif_pcr_req_ready,
    input  logic              htif_pcr_req_rw,
    input  logic [ADDR_W-1:0] htif_pcr_req_addr,
    input  logic [PCR_W-1:0]  htif_pcr_req_data,
    output logic              htif_pcr_resp_valid,
    input  logic              htif_pcr_resp_ready,
    output logic [PCR_W-1:0]  htif_pcr_resp_data,
    input  logic              tohost_wen,
    input  logic [PCR_W-1:0]  tohost_wdata,
    input  logic              fromhost_clr,
    output logic [PCR_W-1:0]  fromhost,
    output logic [PCR_W-1:0]  tohost
);

    htif_state_t      state;
    logic [PCR_W-1:0] rd_data;
    logic             is_to_host;
    logic             is_from_host;

`ifdef VSCALE_HTIF_CYCLE_CSR_EN
    logic [63:0] cycle_count;

    vscale_cycle_counter u_cycle (
        .clk   (clk),
        .reset (reset),
        .count (cycle_count)
    );
`endif

    assign is_to_host   = (htif_pcr_req_addr == ADDR_W'(CSR_ADDR_TO_HOST));
    assign is_from_host = (htif_pcr_req_addr == ADDR_W'(CSR_ADDR_FROM_HOST));

    assign htif_pcr_req_ready  = (state == HTIF_ST_IDLE);
    assign htif_pcr_resp_valid = (state == HTIF_ST_RESP);

    always_comb begin
        rd_data = '0;
        if (!htif_pcr_req_rw) begin
            if (is_to_host) begin
                rd_data = tohost;
            end else if (is_from_host) begin
                rd_data = fromhost;
            end
`ifdef VSCALE_HTIF_CYCLE_CSR_EN
            else if (htif_pcr_req_addr == ADDR_W'(CSR_ADDR_CYCLE)) begin
                rd_data = PCR_W'(cycle_count);
            end
`endif
        end
    end

    // Core strobes are applied around the host case so that the core wins on tohost
    // and the host wins on fromhost when both touch the register in one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state              <= HTIF_ST_IDLE;
            htif_pcr_resp_data <= '0;
            tohost             <= '0;
            fromhost           <= '0;
        end else begin
            if (fromhost_clr) begin
                fromhost <= '0;
            end
            case (state)
                HTIF_ST_IDLE: begin
                    if (htif_pcr_req_valid) begin
                        state              <= HTIF_ST_RESP;
                        htif_pcr_resp_data <= rd_data;
                        if (!htif_pcr_req_rw && is_to_host) begin
                            tohost <= '0;
                        end
                        if (htif_pcr_req_rw && is_from_host) begin
                            fromhost <= htif_pcr_req_data;
                        end
                    end
                end
                HTIF_ST_RESP: begin
                    if (htif_pcr_resp_ready) begin
                        state <= HTIF_ST_IDLE;
                    end
                end
                default: state <= HTIF_ST_IDLE;
            endcase
            if (tohost_wen) begin
                tohost <= tohost_wdata;
            end
        end
    end

endmodule

// File: tb/tb_vscale_htif_pcr_responder.sv
// Randomized self-checking bench for vscale_htif_pcr_responder against a mailbox-level reference model.
// Cycle CSR expectations follow VSCALE_HTIF_CYCLE_CSR_EN.
module tb_vscale_htif_pcr_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_rw;
    logic [11:0] req_addr;
    logic [63:0] req_data;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_data;
    logic        tohost_wen;
    logic [63:0] tohost_wdata;
    logic        fromhost_clr;
    logic [63:0] fromhost;
    logic [63:0] tohost;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: the two mailboxes and the number of clock edges seen since reset release.
    logic [63:0] m_tohost;
    logic [63:0] m_fromhost;
    logic [63:0] edges;

    always #5 clk = ~clk;

    always @(posedge clk or posedge reset) begin
        if (reset) edges <= 64'd0;
        else       edges <= edges + 64'd1;
    end

    vscale_htif_pcr_responder dut (
        .clk                 (clk),
        .reset               (reset),
        .htif_pcr_req_valid  (req_valid),
        .htif_pcr_req_ready  (req_ready),
        .htif_pcr_req_rw     (req_rw),
        .htif_pcr_req_addr   (req_addr),
        .htif_pcr_req_data   (req_data),
        .htif_pcr_resp_valid (resp_valid),
        .htif_pcr_resp_ready (resp_ready),
        .htif_pcr_resp_data  (resp_data),
        .tohost_wen          (tohost_wen),
        .tohost_wdata        (tohost_wdata),
        .fromhost_clr        (fromhost_clr),
        .fromhost            (fromhost),
        .tohost              (tohost)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, ".tohost"}, tohost, m_tohost);
        check({tag, ".fromhost"}, fromhost, m_fromhost);
    endtask

    // One full host transaction: drive at posedge+1, accept on the next edge, hold the
    // response for 'hold' cycles with resp_ready low, then complete the handshake.
    task automatic do_req(input string tag, input logic rw, input logic [11:0] addr,
                          input logic [63:0] data, input int hold,
                          input logic wen, input logic [63:0] wdata, input logic clr);
        logic [63:0] exp;
        exp = 64'd0;
        if (!rw) begin
            if (addr == 12'h780) exp = m_tohost;
            else if (addr == 12'h781) exp = m_fromhost;
`ifdef VSCALE_HTIF_CYCLE_CSR_EN
            else if (addr == 12'hC00) exp = edges;
`endif
        end
        check({tag, ".req_ready_pre"}, {63'd0, req_ready}, 64'd1);
        req_valid    = 1'b1;
        req_rw       = rw;
        req_addr     = addr;
        req_data     = data;
        tohost_wen   = wen;
        tohost_wdata = wdata;
        fromhost_clr = clr;
        resp_ready   = 1'b0;
        if (!rw && addr == 12'h780) m_tohost = 64'd0;
        if (wen) m_tohost = wdata;
        if (clr) m_fromhost = 64'd0;
        if (rw && addr == 12'h781) m_fromhost = data;
        @(posedge clk);
        #1;
        req_valid    = 1'b0;
        tohost_wen   = 1'b0;
        fromhost_clr = 1'b0;
        check({tag, ".resp_valid"}, {63'd0, resp_valid}, 64'd1);
        check({tag, ".resp_data"}, resp_data, exp);
        check({tag, ".req_ready_busy"}, {63'd0, req_ready}, 64'd0);
        check_state(tag);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check({tag, ".hold_valid"}, {63'd0, resp_valid}, 64'd1);
            check({tag, ".hold_data"}, resp_data, exp);
            check({tag, ".hold_ready"}, {63'd0, req_ready}, 64'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        check({tag, ".done_valid"}, {63'd0, resp_valid}, 64'd0);
        check({tag, ".done_ready"}, {63'd0, req_ready}, 64'd1);
    endtask

    task automatic core_cycle(input string tag, input logic wen, input logic [63:0] wdata,
                              input logic clr);
        tohost_wen   = wen;
        tohost_wdata = wdata;
        fromhost_clr = clr;
        if (wen) m_tohost = wdata;
        if (clr) m_fromhost = 64'd0;
        @(posedge clk);
        #1;
        tohost_wen   = 1'b0;
        fromhost_clr = 1'b0;
        check_state(tag);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        #3;
        m_tohost   = 64'd0;
        m_fromhost = 64'd0;
        reset = 1'b0;
    endtask

    initial begin
        logic [11:0] addr;
        logic [63:0] d;
        reset        = 1'b1;
        req_valid    = 1'b0;
        req_rw       = 1'b0;
        req_addr     = 12'd0;
        req_data     = 64'd0;
        resp_ready   = 1'b0;
        tohost_wen   = 1'b0;
        tohost_wdata = 64'd0;
        fromhost_clr = 1'b0;
        m_tohost     = 64'd0;
        m_fromhost   = 64'd0;
        #12;
        check("rst.req_ready", {63'd0, req_ready}, 64'd1);
        check("rst.resp_valid", {63'd0, resp_valid}, 64'd0);
        check("rst.resp_data", resp_data, 64'd0);
        check_state("rst");
        #10;
        reset = 1'b0;
        @(posedge clk);
        #1;

        core_cycle("core_wr5", 1'b1, 64'd5, 1'b0);
        do_req("rd_tohost", 1'b0, 12'h780, 64'd0, 0, 1'b0, 64'd0, 1'b0);
        do_req("rd_tohost2", 1'b0, 12'h780, 64'd0, 0, 1'b0, 64'd0, 1'b0);
        do_req("wr_fromhost", 1'b1, 12'h781, 64'hABCD, 0, 1'b0, 64'd0, 1'b0);
        core_cycle("fromhost_clr", 1'b0, 64'd0, 1'b1);
        core_cycle("core_wr3", 1'b1, 64'd3, 1'b0);
        do_req("stall_rd", 1'b0, 12'h780, 64'd0, 4, 1'b0, 64'd0, 1'b0);
        core_cycle("core_wr3b", 1'b1, 64'd3, 1'b0);
        do_req("race_tohost", 1'b0, 12'h780, 64'd0, 0, 1'b1, 64'd7, 1'b0);
        do_req("race_fromhost", 1'b1, 12'h781, 64'd9, 0, 1'b0, 64'd0, 1'b1);
        do_req("rd_unmapped", 1'b0, 12'h123, 64'd0, 0, 1'b0, 64'd0, 1'b0);
        do_req("rd_cycle", 1'b0, 12'hC00, 64'd0, 1, 1'b0, 64'd0, 1'b0);
        do_req("wr_tohost_ign", 1'b1, 12'h780, 64'h55, 0, 1'b0, 64'd0, 1'b0);
        do_req("wr_cycle_ign", 1'b1, 12'hC00, 64'h77, 0, 1'b0, 64'd0, 1'b0);

        for (int k = 0; k < 150; k++) begin
            case ($urandom_range(0, 4))
                0: addr = 12'h780;
                1: addr = 12'h781;
                2: addr = 12'hC00;
                default: addr = 12'($urandom_range(0, 4095));
            endcase
            d = {$urandom, $urandom};
            if ($urandom_range(0, 2) == 0) begin
                core_cycle("rnd_core", 1'($urandom_range(0, 1)), {$urandom, $urandom},
                           1'($urandom_range(0, 1)));
            end
            do_req("rnd", 1'($urandom_range(0, 1)), addr, d, int'($urandom_range(0, 3)),
                   ($urandom_range(0, 3) == 0), {$urandom, $urandom},
                   ($urandom_range(0, 3) == 0));
        end

        // Asynchronous reset while a response is pending.
        core_cycle("pre_rst", 1'b1, 64'h1234, 1'b0);
        do_req("pre_rst_wr", 1'b1, 12'h781, 64'h99, 0, 1'b0, 64'd0, 1'b0);
        req_valid = 1'b1;
        req_rw    = 1'b0;
        req_addr  = 12'h781;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("arst.pending", {63'd0, resp_valid}, 64'd1);
        #1;
        reset = 1'b1;
        #1;
        check("arst.resp_valid", {63'd0, resp_valid}, 64'd0);
        check("arst.req_ready", {63'd0, req_ready}, 64'd1);
        check("arst.resp_data", resp_data, 64'd0);
        check("arst.tohost", tohost, 64'd0);
        check("arst.fromhost", fromhost, 64'd0);
        apply_reset();
        @(posedge clk);
        #1;
        check("post_rst.resp_valid", {63'd0, resp_valid}, 64'd0);
        do_req("post_rst_cycle", 1'b0, 12'hC00, 64'd0, 0, 1'b0, 64'd0, 1'b0);
        do_req("post_rst_from", 1'b0, 12'h781, 64'd0, 0, 1'b0, 64'd0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vscale_htif_pcr_responder.md
# vscale_htif_pcr_responder

Target-side responder for the HTIF PCR request/response channel. It receives host requests, serves the `tohost`/`fromhost` mailbox registers, and returns exactly one response per accepted request. It sits between the host-facing `htif_pcr_*` ports of the sim top and the core. The core writes `tohost` and consumes `fromhost` through a simple register port.

## Interface
Parameters:
- `PCR_W`, default `HTIF_PCR_WIDTH` (64): request and response data width.
- `ADDR_W`, default `CSR_ADDR_WIDTH` (12): PCR address width.

Ports:
- `clk`  in  1  clock; all state is updated on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `htif_pcr_req_valid`  in  1  host request valid.
- `htif_pcr_req_ready`  out  1  responder can accept a request.
- `htif_pcr_req_rw`  in  1  1 = write, 0 = read.
- `htif_pcr_req_addr`  in  ADDR_W  PCR address.
- `htif_pcr_req_data`  in  PCR_W  write data.
- `htif_pcr_resp_valid`  out  1  response valid.
- `htif_pcr_resp_ready`  in  1  host accepts the response.
- `htif_pcr_resp_data`  out  PCR_W  response data.
- `tohost_wen`  in  1  core write strobe for `tohost`.
- `tohost_wdata`  in  PCR_W  core write data for `tohost`.
- `fromhost_clr`  in  1  core has consumed `fromhost`; clears it to 0.
- `fromhost`  out  PCR_W  current `fromhost` value.
- `tohost`  out  PCR_W  current `tohost` value, for debug and trace.

## Operation
- The FSM has two states, `IDLE` and `RESP`. Reset state is `IDLE`.
- `htif_pcr_req_ready` = (state == `IDLE`).
- A request is accepted when `req_valid & req_ready` at a clock edge. On acceptance the FSM moves to `RESP` and `resp_data` is loaded:
  - Read of `CSR_ADDR_TO_HOST` (0x780): returns `tohost`, then clears `tohost` to 0.
  - Read of `CSR_ADDR_FROM_HOST` (0x781): returns `fromhost`.
  - Write of `CSR_ADDR_FROM_HOST`: `fromhost` <= `req_data`; response data is 0.
  - Write of `CSR_ADDR_TO_HOST`: ignored; response data is 0.
  - Any other address: a read returns 0 and a write is ignored. A response is always produced.
- `RESP` to `IDLE` happens when `resp_valid & resp_ready`. `resp_data` holds stable while `resp_valid` is high and `resp_ready` is low.
- Core port:
  - `tohost_wen` writes `tohost` in any state.
  - `fromhost_clr` zeroes `fromhost` in any state.
- Simultaneous events:
  - Core `tohost_wen` in the same cycle as a host read-clear of `tohost`: the core write wins, so `tohost` = `tohost_wdata`. The response carries the old value.
  - Host write of `fromhost` in the same cycle as `fromhost_clr`: the host write wins.
- Reset mid-operation: reset asynchronously forces `IDLE`, `resp_valid`=0, `resp_data`=0, `tohost`=0, `fromhost`=0. Any pending response is dropped.

## Timing
- Reset values: `htif_pcr_req_ready`=1, `htif_pcr_resp_valid`=0, `htif_pcr_resp_data`=0, `tohost`=0, `fromhost`=0.
- Latency: a request accepted at edge N gives `resp_valid`=1 in cycle N+1. Side effects on `tohost`/`fromhost` are visible in cycle N+1.
- `req_ready` is low from cycle N+1 until the edge where the response handshake completes. It is high again in the following cycle.
- With `resp_ready` held at 1, `resp_valid` is a one-cycle pulse. Maximum throughput is one request per 2 cycles.
- There are no combinational paths from `resp_ready` or `req_valid` to any output.

## Configuration
- Macro: `VSCALE_HTIF_CYCLE_CSR_EN`.
- Defined:
  - A 64-bit free-running counter resets to 0 and increments every cycle, wrapping at 2^64−1 to 0.
  - A host read of `CSR_ADDR_CYCLE` (0xC00) returns the counter value sampled at the acceptance edge. A write to that address is ignored.
- Undefined:
  - No counter logic is built.
  - 0xC00 is treated as unmapped: reads return 0.

## Structure
- PCR addresses (`CSR_ADDR_TO_HOST`, `CSR_ADDR_FROM_HOST`, `CSR_ADDR_CYCLE`) live in the shared CSR address map header.
- `HTIF_PCR_WIDTH` and `CSR_ADDR_WIDTH` live in the shared control constants header.
- FSM state encodings (`HTIF_ST_IDLE`, `HTIF_ST_RESP`) go in the shared control constants header.
- One sub-module: `vscale_cycle_counter`, instantiated only under `VSCALE_HTIF_CYCLE_CSR_EN`.

## Test plan
- Reset, then core writes `tohost`=5. Host reads 0x780 → resp_data=5 in the cycle after acceptance; `tohost`=0 afterwards; a second read returns 0.
- Host writes 0x781 with 0xABCD, `resp_ready`=1 → resp_data=0, `fromhost`=0xABCD. Then pulse `fromhost_clr` → `fromhost`=0.
- Host reads 0x780 with `resp_ready` held at 0 for 4 cycles → `resp_valid` and `resp_data` stable and `req_ready`=0 throughout. Assert `resp_ready` → `req_ready`=1 in the next cycle.
- Host read-clear of `tohost`=3 in the same cycle as core `tohost_wen` with 7 → response data 3, `tohost`=7. Separately, a host write of `fromhost` with 9 coincident with `fromhost_clr` → `fromhost`=9.
- Host reads 0x123 → response 0. Host reads 0xC00 → response equals the counter value at acceptance with the macro defined, and 0 without it.
- Assert `reset` asynchronously while in `RESP` → `resp_valid`=0 and `req_ready`=1 immediately, before the next edge; `tohost`=`fromhost`=0.
